recepcao_serial_pedidos: RTL

//   Receive side of the SmartCargo serial link. Takes bytes from the UART receiver,

---
 rtl/recepcao_serial_pedidos.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/recepcao_serial_pedidos.sv
// ---------------------------------------------------------------------------
// recepcao_serial_pedidos
//   Receive side of the SmartCargo serial link. Parses 4-byte request frames
//   ('#', origin digit, destination digit, LF) arriving from the UART
//   receiver. Each valid frame becomes one origin/destination request, offered
//   on a valid/accept handshake to the elevator queue writer. Malformed,
//   out-of-range or stalled frames are discarded and counted.
//
// Ports
//   clock           in   rising-edge system clock
//   reset           in   synchronous, active-high
//   dado_rx         in   received byte, meaningful only while dado_rx_pronto=1
//   dado_rx_pronto  in   one-cycle strobe per received byte
//   pedido_aceito   in   queue writer takes the pending request
//   pedido_valido   out  request available, held until accepted
//   pedido_origem   out  origin floor, stable while pedido_valido=1
//   pedido_destino  out  destination floor, stable while pedido_valido=1
//   erro_quadro     out  one-cycle pulse per discarded frame
//   contagem_erros  out  discarded-frame count, saturating at 255
//   ocupado         out  1 whenever the parser is not idle
//   db_estado       out  current state encoding for the debug display
// ---------------------------------------------------------------------------
module recepcao_serial_pedidos #(
   parameter int            N_ANDARES      = 4,
   parameter int            ANDAR_W        = 2,
   parameter int            TIMEOUT_CICLOS = 50000,
   parameter int            TIMEOUT_W      = 16,
   parameter logic [7:0]    BYTE_INICIO    = 8'h23,
   parameter logic [7:0]    BYTE_FIM       = 8'h0A
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [7:0]         dado_rx,
   input  logic               dado_rx_pronto,
   input  logic               pedido_aceito,
   output logic               pedido_valido,
   output logic [ANDAR_W-1:0] pedido_origem,
   output logic [ANDAR_W-1:0] pedido_destino,
   output logic               erro_quadro,
   output logic [7:0]         contagem_erros,
   output logic               ocupado,
   output logic [3:0]         db_estado
);

   typedef enum logic [3:0] {
      ESPERA_INICIO  = 4'd0,
      ESPERA_ORIGEM  = 4'd1,
      ESPERA_DESTINO = 4'd2,
      ESPERA_FIM     = 4'd3,
      PEDIDO         = 4'd4,
      ERRO           = 4'd5
   } estado_t;

   localparam logic [7:0]           DIGITO_MIN  = 8'h30;
   localparam logic [7:0]           DIGITO_MAX  = 8'(8'h30 + N_ANDARES - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CICLOS);

   estado_t              estado_q;
   logic [TIMEOUT_W-1:0] timeout_q;
   logic [ANDAR_W-1:0]   origem_q;
   logic [ANDAR_W-1:0]   destino_q;
   logic [ANDAR_W-1:0]   pedido_origem_q;
   logic [ANDAR_W-1:0]   pedido_destino_q;
   logic                 pedido_valido_q;
   logic                 erro_quadro_q;
   logic [7:0]           contagem_erros_q;
   logic                 ocupado_q;

   logic                 digito_valido;
   logic [ANDAR_W-1:0]   digito;
   logic                 entra_erro;

   assign digito_valido = (dado_rx >= DIGITO_MIN) && (dado_rx <= DIGITO_MAX);
   assign digito        = ANDAR_W'(dado_rx - DIGITO_MIN);

   // Frame-level failure detection for the three in-frame states. A byte in
   // the same cycle as the timeout takes priority, and '#' always restarts
   // the frame instead of failing it.
   always_comb begin
      entra_erro = 1'b0;
      if (estado_q inside {ESPERA_ORIGEM, ESPERA_DESTINO, ESPERA_FIM}) begin
         if (dado_rx_pronto) begin
            if (dado_rx != BYTE_INICIO) begin
               case (estado_q)
                  ESPERA_ORIGEM:  entra_erro = !digito_valido;
                  ESPERA_DESTINO: entra_erro = !digito_valido || (digito == origem_q);
                  ESPERA_FIM:     entra_erro = (dado_rx != BYTE_FIM);
                  default:        entra_erro = 1'b0;
               endcase
            end
         end else begin
            entra_erro = (timeout_q == TIMEOUT_MAX);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q         <= ESPERA_INICIO;
         timeout_q        <= '0;
         origem_q         <= '0;
         destino_q        <= '0;
         pedido_origem_q  <= '0;
         pedido_destino_q <= '0;
         pedido_valido_q  <= 1'b0;
         erro_quadro_q    <= 1'b0;
         contagem_erros_q <= '0;
         ocupado_q        <= 1'b0;
      end else begin
         erro_quadro_q <= 1'b0;
         case (estado_q)
            ESPERA_INICIO: begin
               if (dado_rx_pronto && (dado_rx == BYTE_INICIO)) begin
                  estado_q  <= ESPERA_ORIGEM;
                  ocupado_q <= 1'b1;
                  timeout_q <= '0;
               end
            end

            ESPERA_ORIGEM, ESPERA_DESTINO, ESPERA_FIM: begin
               if (entra_erro) begin
                  // The error flag is raised on entry so it is high for
                  // exactly the single cycle spent in ERRO.
                  estado_q      <= ERRO;
                  erro_quadro_q <= 1'b1;
                  if (contagem_erros_q != 8'hFF) begin
                     contagem_erros_q <= contagem_erros_q + 8'd1;
                  end
               end else if (dado_rx_pronto) begin
                  timeout_q <= '0;
                  if (dado_rx == BYTE_INICIO) begin
                     estado_q <= ESPERA_ORIGEM;
                  end else begin
                     case (estado_q)
                        ESPERA_ORIGEM: begin
                           origem_q <= digito;
                           estado_q <= ESPERA_DESTINO;
                        end
                        ESPERA_DESTINO: begin
                           destino_q <= digito;
                           estado_q  <= ESPERA_FIM;
                        end
                        default: begin
                           // Output fields are loaded only here so that a
                           // later broken frame cannot disturb them.
                           pedido_origem_q  <= origem_q;
                           pedido_destino_q <= destino_q;
                           pedido_valido_q  <= 1'b1;
                           estado_q         <= PEDIDO;
                        end
                     endcase
                  end
               end else begin
                  timeout_q <= timeout_q + 1'b1;
               end
            end

            PEDIDO: begin
               if (pedido_aceito) begin
                  pedido_valido_q <= 1'b0;
                  ocupado_q       <= 1'b0;
                  estado_q        <= ESPERA_INICIO;
               end
            end

            default: begin
               // ERRO and any unreachable encoding return to idle.
               pedido_valido_q <= 1'b0;
               ocupado_q       <= 1'b0;
               estado_q        <= ESPERA_INICIO;
            end
         endcase
      end
   end

   assign pedido_valido  = pedido_valido_q;
   assign pedido_origem  = pedido_origem_q;
   assign pedido_destino = pedido_destino_q;
   assign erro_quadro    = erro_quadro_q;
   assign contagem_erros = contagem_erros_q;
   assign ocupado        = ocupado_q;
   assign db_estado      = estado_q;

endmodule
